// File: rtl/brent_kung_subtractor32bit_pipe.sv
// brent_kung_subtractor32bit_pipe
//   Two-stage pipelined 32-bit subtractor: diff = a - b - borrowIn (mod 2^32).
//   The subtraction runs through a Brent-Kung prefix adder as a + ~b + ~borrowIn.
//   S1 holds the operands. S2 holds the result and flags. Both sides use valid/ready.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (in_a, in_b, borrowIn)
//   out_valid/out_ready   result handshake (diff, borrowOut, overflow, zero)

// brent_kung_adder32bit
//   Combinational 32-bit Brent-Kung prefix adder.
// Ports
//   in1, in2       operands
//   carryIn        carry-in
//   outputFinal    sum
//   carryOutFinal  carry-out
module brent_kung_adder32bit (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        carryIn,
  output logic [31:0] outputFinal,
  output logic        carryOutFinal
);
  logic [31:0] g0, p0, gf, pf;
  logic [32:0] c;

  assign g0 = in1 & in2;
  assign p0 = in1 ^ in2;

  // Nine prefix levels. Levels 0-4 form the up-sweep, with spans 1, 2, 4, 8 and 16.
  // Levels 5-8 form the down-sweep, with spans 8, 4, 2 and 1. After the last level,
  // (gf[i], pf[i]) is the group generate/propagate for bits [i:0].
  for (genvar l = 0; l < 9; l++) begin : g_lvl
    localparam int D = (l < 5) ? (1 << l) : (1 << (8 - l));
    logic [31:0] gi, pin, go, po;
    if (l == 0) begin : g_src0
      assign gi  = g0;
      assign pin = p0;
    end else begin : g_srcn
      assign gi  = g_lvl[l-1].go;
      assign pin = g_lvl[l-1].po;
    end
    for (genvar i = 0; i < 32; i++) begin : g_bit
      localparam bit UP = (l < 5)  && (((i + 1) % (2 * D)) == 0);
      localparam bit DN = (l >= 5) && (((i + 1) % (2 * D)) == D) && (i >= 2 * D);
      if (UP || DN) begin : g_op
        assign go[i] = gi[i] | (pin[i] & gi[i-D]);
        assign po[i] = pin[i] & pin[i-D];
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pin[i];
      end
    end
  end

  assign gf = g_lvl[8].go;
  assign pf = g_lvl[8].po;

  // The carry-in is folded in after the tree: c[i+1] = G[i:0] | P[i:0] & cin.
  assign c[0]      = carryIn;
  assign c[32:1]   = gf | (pf & {32{carryIn}});
  assign outputFinal   = p0 ^ c[31:0];
  assign carryOutFinal = c[32];
endmodule

module brent_kung_subtractor32bit_pipe #(
  parameter int WIDTH = 32  // fixed by the embedded 32-bit adder
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             borrowIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
  output logic             overflow,
  output logic             zero
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe_d, vld_pipe_q;
  logic [WIDTH-1:0] a_d, a_q, bn_d, bn_q, diff_d, diff_q;
  logic cin_d, cin_q, borrow_d, borrow_q, ovf_d, ovf_q, zero_d, zero_q;
  logic [WIDTH-1:0] sum;
  logic cout, s2_free, s1_adv, in_xfer;

  brent_kung_adder32bit u_add (
    .in1          (a_q),
    .in2          (bn_q),
    .carryIn      (cin_q),
    .outputFinal  (sum),
    .carryOutFinal(cout)
  );

  always_comb begin
    s2_free  = !vld_pipe_q[2] || out_ready;
    s1_adv   = vld_pipe_q[1] && s2_free;
    in_ready = !vld_pipe_q[1] || s1_adv;
    in_xfer  = in_valid && in_ready;

    a_d      = a_q;
    bn_d     = bn_q;
    cin_d    = cin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    // A stage that drains and refills on the same edge stays valid.
    vld_pipe_d[1] = in_xfer || (vld_pipe_q[1] && !s1_adv);
    vld_pipe_d[2] = s1_adv  || (vld_pipe_q[2] && !out_ready);

    if (in_xfer) begin
      a_d   = in_a;
      bn_d  = ~in_b;
      cin_d = ~borrowIn;
    end
    if (s1_adv) begin
      diff_d   = sum;
      borrow_d = ~cout;
      // bn_q holds ~b. The operand signs differ exactly when a[31] == bn_q[31].
      ovf_d    = (a_q[WIDTH-1] == bn_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      zero_d   = (sum == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      bn_q       <= '0;
      cin_q      <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      a_q        <= a_d;
      bn_q       <= bn_d;
      cin_q      <= cin_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign diff      = diff_q;
  assign borrowOut = borrow_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_brent_kung_subtractor32bit_pipe.sv
// Directed bench for brent_kung_subtractor32bit_pipe.
// It covers reset, latency, corner vectors, streaming, backpressure and mid-flight reset.
module tb_brent_kung_subtractor32bit_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, borrowIn, out_valid, out_ready;
  logic        borrowOut, overflow, zero;
  logic [31:0] in_a, in_b, diff;

  int n_chk = 0, n_err = 0, cyc = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        bo, ov, z;
  } res_t;
  res_t exp_q[$];

  always #5 clk = ~clk;

  brent_kung_subtractor32bit_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .borrowIn(borrowIn), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrowOut(borrowOut),
    .overflow(overflow), .zero(zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference subtraction, computed with 33-bit arithmetic.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] r;
    res_t o;
    r    = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    o.d  = r[31:0];
    o.bo = r[32];
    o.ov = (a[31] != b[31]) && (r[31] != a[31]);
    o.z  = (r[31:0] == 32'd0);
    return o;
  endfunction

  // Call at a negedge with inputs already driven. The task scores both handshakes
  // and then advances to the next negedge.
  task automatic step(input string tag);
    res_t e;
    #1;
    if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, borrowIn));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk({tag, " spurious"}, 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk({tag, " diff"}, diff, e.d);
        chk({tag, " flags"}, {29'd0, borrowOut, overflow, zero}, {29'd0, e.bo, e.ov, e.z});
      end
    end
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic bin, input logic [31:0] ed, input logic eb,
                            input logic eo, input logic ez);
    in_a = a; in_b = b; borrowIn = bin; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = 32'hDEADBEEF; in_b = 32'h12345678; borrowIn = 1'b1;
    #1 chk({tag, " ov after 1 edge"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, " ov after 2 edges"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " borrow"}, {31'd0, borrowOut}, {31'd0, eb});
    chk({tag, " ovf"}, {31'd0, overflow}, {31'd0, eo});
    chk({tag, " zero"}, {31'd0, zero}, {31'd0, ez});
    @(negedge clk);
  endtask

  logic [31:0] sa [8] = '{32'h00000010, 32'h7FFFFFFF, 32'h80000000, 32'h12345678,
                          32'h00000000, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h00000005};
  logic [31:0] sb [8] = '{32'h00000003, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678,
                          32'h00000000, 32'h00000001, 32'h5A5A5A5A, 32'h00000006};
  logic        sbi[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int first_out, last_out, n_out, guard;
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; borrowIn = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst diff", diff, 32'd0);
    chk("rst flags", {29'd0, borrowOut, overflow, zero}, 32'd0);
    rst = 1'b0;
    #1 chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Directed corner vectors
    run_single("t1 2-1",        32'h00000002, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_single("t2 0-1",        32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_single("t2 min-1",      32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    run_single("t3 1515-0B0B",  32'h15151515, 32'h0B0B0B0B, 1'b0, 32'h0A0A0A0A, 1'b0, 1'b0, 1'b0);
    run_single("t3 F-F bin0",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    run_single("t3 F-F bin1",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

    // Streaming: 8 ops back to back, results expected on 8 consecutive cycles
    exp_q.delete();
    out_ready = 1'b1; first_out = -1; last_out = -1; n_out = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = sa[i]; in_b = sb[i]; borrowIn = sbi[i];
      #1 if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc; n_out++;
      end
      step("t4 stream");
    end
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      #1 if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc; n_out++;
      end
      step("t4 drain");
      guard++;
    end
    chk("t4 drained", exp_q.size(), 32'd0);
    chk("t4 result count", n_out, 32'd8);
    chk("t4 consecutive", last_out - first_out, 32'd7);

    // Backpressure: 3 offered with out_ready=0
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h00000100; in_b = 32'h00000001; borrowIn = 1'b0;
    step("t5 op0");
    in_a = 32'h80000000; in_b = 32'h7FFFFFFF; borrowIn = 1'b0;
    step("t5 op1");
    in_a = 32'h00000007; in_b = 32'h00000009; borrowIn = 1'b1;
    #1 chk("t5 in_ready blocked", {31'd0, in_ready}, 32'd0);
    chk("t5 accepted two", exp_q.size(), 32'd2);
    held = diff;
    chk("t5 held diff first", held, 32'h000000FF);
    for (int k = 0; k < 3; k++) begin
      step("t5 stall");
      chk("t5 stall out_valid", {31'd0, out_valid}, 32'd1);
      chk("t5 stall diff stable", diff, held);
    end
    out_ready = 1'b1;
    guard = 0;
    while (in_valid && guard < 10) begin
      #1 if (in_ready) begin
        step("t5 release");
        in_valid = 1'b0;
      end else step("t5 release");
      guard++;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      step("t5 drain");
      guard++;
    end
    chk("t5 all emerged", exp_q.size(), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 32'h00001000; in_b = 32'h00000001; borrowIn = 1'b0;
    step("t6 fill0");
    in_a = 32'h00002000;
    step("t6 fill1");
    in_valid = 1'b0;
    #1 chk("t6 full out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1 chk("t6 rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6 rst diff", diff, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t6 no stale", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    run_single("t6 after rst", 32'h00000064, 32'h00000032, 1'b1, 32'h00000031, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
